// File: rtl/regfile_write_bank_if.sv
// Write-side bus of the register file: write request in, packed register contents out.
// The master drives the write request; the slave (the register bank) drives regs.
interface regfile_write_bank_if #(
    parameter int WIDTH = 64
);
    logic                        RegWrite;
    logic [4:0]                  WriteRegister;
    logic [WIDTH-1:0]            WriteData;
    logic [31:0][WIDTH-1:0]      regs;

    modport master (
        output RegWrite,
        output WriteRegister,
        output WriteData,
        input  regs
    );

    modport slave (
        input  RegWrite,
        input  WriteRegister,
        input  WriteData,
        output regs
    );
endinterface

// File: rtl/regfile_write_bank.sv
// 32-entry register file write bank: one-hot write decode, enabled storage flops,
// and a packed bus of all registers for the read muxes. ZERO_REG is hardwired to 0.
module regfile_write_bank #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_write_bank_if.slave  bus
);

    for (genvar k = 0; k < 32; k++) begin : g_reg
        if (k == ZERO_REG) begin : g_zero
            // Not stored at all, so writes to it are dropped by construction.
            assign bus.regs[k] = '0;
        end else begin : g_store
            logic             w_wen;
            logic [WIDTH-1:0] r_q;

            assign w_wen = bus.RegWrite && (bus.WriteRegister == 5'(k));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= '0;
                end else if (w_wen) begin
                    r_q <= bus.WriteData;
                end
            end

            assign bus.regs[k] = r_q;
        end
    end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed bench for regfile_write_bank: vector table plus hand-written reset sequences.
module tb_regfile_write_bank;

    localparam logic [63:0] BASE = 64'h0123_4567_89AB_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] DEAD = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk;
    logic reset;

    regfile_write_bank_if #(.WIDTH(64)) bus ();

    regfile_write_bank #(.WIDTH(64), .ZERO_REG(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [63:0] data;
        logic [4:0]  chk_addr;
        logic [63:0] chk_val;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] model [32];
    int          checks;
    int          failures;

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s reg=%0d got=%h exp=%h @%0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name);
        for (int k = 0; k < 32; k++) chk(name, k, bus.regs[k], model[k]);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 32; k++) model[k] = '0;
    endtask

    // Drive a request, take one rising edge, settle 1ns after it.
    task automatic drive_edge(input logic we, input logic [4:0] a, input logic [63:0] d);
        bus.RegWrite      = we;
        bus.WriteRegister = a;
        bus.WriteData     = d;
        @(posedge clk);
        #1;
        if (we && a != 5'd31 && !reset) model[a] = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_model();
        reset             = 1'b0;
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd5;
        bus.WriteData     = ONES;

        // Reset acts before any clock edge, then dominates a pending write for 3 edges.
        #1 reset = 1'b1;
        #1 check_all("reset_async_initial");
        for (int e = 0; e < 3; e++) begin
            drive_edge(1'b1, 5'd5, ONES);
            check_all("reset_hold");
        end
        #3 reset = 1'b0;
        drive_edge(1'b1, 5'd5, ONES);
        check_all("first_write_after_reset");
        chk("reg5_after_reset", 5, bus.regs[5], ONES);

        for (int k = 0; k < 31; k++)
            vecs.push_back('{1'b1, 5'(k), BASE + 64'(k), 5'(k), BASE + 64'(k)});
        for (int g = 0; g < 4; g++)
            vecs.push_back('{1'b0, 5'd7, DEAD, 5'd7, 64'h0123_4567_89AB_0007});
        vecs.push_back('{1'b1, 5'd31, ONES, 5'd31, 64'h0});
        vecs.push_back('{1'b1, 5'd12, 64'h1, 5'd12, 64'h1});
        vecs.push_back('{1'b1, 5'd12, 64'h2, 5'd12, 64'h2});
        vecs.push_back('{1'b1, 5'd12, 64'h3, 5'd12, 64'h3});
        vecs.push_back('{1'b0, 5'd12, 64'h4, 5'd12, 64'h3});
        vecs.push_back('{1'b0, 5'd30, 64'h5, 5'd30, 64'h0123_4567_89AB_001E});

        foreach (vecs[i]) begin
            drive_edge(vecs[i].we, vecs[i].addr, vecs[i].data);
            chk("vector", int'(vecs[i].chk_addr), bus.regs[vecs[i].chk_addr], vecs[i].chk_val);
            check_all("vector_all");
        end

        // Glitch address/data between edges with the enable low.
        bus.RegWrite = 1'b0;
        for (int g = 0; g < 5; g++) begin
            #1 bus.WriteRegister = 5'(g * 3);
            bus.WriteData = DEAD ^ 64'(g);
        end
        @(posedge clk);
        #1 check_all("glitch_hold");

        // Reset asserted between edges halfway through a fresh sweep.
        clear_model();
        reset = 1'b1;
        #1 check_all("mid_reset_prep");
        #2 reset = 1'b0;
        for (int k = 0; k < 16; k++) drive_edge(1'b1, 5'(k), ~(BASE + 64'(k)));
        check_all("half_sweep");
        bus.RegWrite = 1'b0;
        #3 reset = 1'b1;
        clear_model();
        #1 check_all("mid_sweep_async_reset");
        #1 reset = 1'b0;
        for (int k = 16; k < 31; k++) drive_edge(1'b1, 5'(k), BASE ^ 64'(k << 8));
        drive_edge(1'b1, 5'd3, 64'hA5A5_0000_5A5A_FFFF);
        check_all("resume_after_reset");
        chk("reg3_resume", 3, bus.regs[3], 64'hA5A5_0000_5A5A_FFFF);
        chk("reg0_cleared", 0, bus.regs[0], 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_bank.md
# regfile_write_bank

Write side of the 32-entry register file: decodes the destination register number, gates the write enable, and holds the 32 storage registers. Its packed register bus drives the two read-port muxes, which select one 64-bit register from the bus. Register 31 is the zero register: it always reads 0 and ignores writes.

## Interface
Parameters:
- WIDTH, 64, bits per register. The read muxes require 64.
- ZERO_REG, 31, index of the hardwired-zero register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears every register.
- RegWrite  input  1  write enable for the current cycle.
- WriteRegister  input  5  destination register number, 0–31.
- WriteData  input  WIDTH  value to store.
- regs  output  [31:0][WIDTH-1:0]  packed contents of all 32 registers, in index order; feeds the read muxes.

## Operation
- Decoder:
  - A 5:32 one-hot decode of WriteRegister is ANDed with RegWrite to form wen[31:0].
  - At most one wen bit is high; when RegWrite=0, all wen bits are 0.
- Storage: 32 registers r0..r31, each WIDTH D flip-flops with enable.
  - Each bit uses a 2:1 mux on the D input: D = wen[k] ? WriteData[b] : Q.
  - There is no clock gating.
- r[ZERO_REG]:
  - It is not stored; regs[ZERO_REG] is tied to 0.
  - wen[ZERO_REG] has no effect, so a write to register 31 is silently dropped.
- regs[k] = Q of r[k] for every k ≠ ZERO_REG.
- There is no internal read port and no bypass. Write-then-read forwarding within a cycle is not provided; the pipeline handles it.
- Unknown inputs:
  - If RegWrite=1 and WriteRegister contains X/Z, the write target is undefined.
  - The bench must not drive this case. The design need not trap it.

## Timing
- Reset:
  - While reset=1, all regs outputs are 0, asynchronously and independent of clk.
  - Reset dominates: a write presented on the same edge that reset is high is lost.
- Reset deassertion:
  - The first write can occur on the first rising edge after reset falls.
  - reset must meet recovery time to clk.
- Write latency:
  - WriteData is sampled on the rising clk edge where RegWrite=1.
  - regs[WriteRegister] shows the new value after clk-to-Q of that edge, so it is visible to the read muxes in the following cycle.
- Hold:
  - A register keeps its value across any number of cycles with RegWrite=0, or with WriteRegister pointing elsewhere.
- Back-to-back writes:
  - A different register every cycle: each update lands on its own edge.
  - The same register on consecutive edges: the last write wins, with no loss or stall.
- Stability requirements:
  - WriteRegister and WriteData must be stable only around the sampling edge.
  - Glitches on them between edges while RegWrite=0 do not change state.
- Mid-operation reset: asserting reset in the middle of a write sequence clears all registers immediately, including any that were written earlier in the sequence.
- Combinational path: the only path to regs is from flop Q; the inputs have no combinational path to regs.

## Test plan
- Reset:
  - Drive RegWrite=1, WriteRegister=5, WriteData=64'hFFFF_FFFF_FFFF_FFFF and hold reset=1 across 3 edges.
  - Required: every regs[k]==0 throughout.
  - Drop reset and clock once: regs[5]==64'hFFFF_FFFF_FFFF_FFFF, all others 0.
- Write/readback sweep:
  - For k=0..30, write 64'h0123_4567_89AB_0000 + k, one per cycle.
  - Required: after the sweep, regs[k] holds its value for each k, and regs[31]==0.
- Enable gating:
  - With RegWrite=0, drive WriteRegister=7 and WriteData=64'hDEAD_BEEF_DEAD_BEEF for 4 edges.
  - Required: regs[7] keeps its prior value, 64'h0123_4567_89AB_0007.
- Zero register:
  - Write 64'hFFFF_FFFF_FFFF_FFFF to register 31.
  - Required: regs[31]==0 on the next cycle and no other register changes.
- Same-register back-to-back:
  - Write register 12 with 64'h1, 64'h2, 64'h3 on consecutive edges.
  - Required: regs[12] shows 1, 2, 3 in successive cycles and is 3 afterward.
- Asynchronous reset mid-sequence:
  - Assert reset between edges, halfway through the sweep.
  - Required: all regs go to 0 before the next clk edge. Writes resume correctly after deassertion.
